// File: rtl/rvv_backend_pkg.sv
// Shared RVV backend types and sizing macros.
// ALU reservation-station entry layout plus default dimensions.
`ifndef NUM_ALU
`define NUM_ALU 2
`endif
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif
`ifndef ALU_RS_DEPTH
`define ALU_RS_DEPTH 8
`endif

package rvv_backend_pkg;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [4:0]  vd_index;
        logic [31:0] rs1_data;
    } ALU_RS_t;

endpackage

// File: rtl/multi_fifo.sv
// Generic multi-push / multi-pop circular FIFO with registered-count flags
// and combinational read slots.
module multi_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned N_PUSH = 2,
    parameter int unsigned N_POP  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [N_PUSH-1:0]            push,
    input  logic [N_PUSH-1:0][WIDTH-1:0] din,
    output logic                         full,
    output logic [N_PUSH-1:0]            almost_full,
    input  logic [N_POP-1:0]             pop,
    output logic [N_POP-1:0][WIDTH-1:0]  dout,
    output logic                         empty,
    output logic [N_POP-1:0]             almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     push_cnt;
    logic [CW-1:0]     pop_cnt;
    logic [N_PUSH-1:0] push_ok;
    logic [N_POP-1:0]  pop_ok;

    // Flags look only at the registered count; same-cycle pops free nothing.
    always_comb begin
        full        = (cnt == CW'(DEPTH));
        empty       = (cnt == '0);
        almost_full = '0;
        for (int unsigned j = 0; j < N_PUSH; j++)
            almost_full[j] = (CW'(DEPTH) - cnt) < CW'(j + 1);
        almost_empty = '0;
        for (int unsigned i = 0; i < N_POP; i++)
            almost_empty[i] = (cnt <= CW'(i));
    end

    // Only the contiguous low-order prefix of each request vector is honoured.
    always_comb begin
        push_ok    = '0;
        push_ok[0] = push[0] & ~almost_full[0];
        for (int unsigned j = 1; j < N_PUSH; j++)
            push_ok[j] = push_ok[j-1] & push[j] & ~almost_full[j];
        push_cnt = '0;
        for (int unsigned j = 0; j < N_PUSH; j++)
            push_cnt = push_cnt + CW'(push_ok[j]);
    end

    always_comb begin
        pop_ok    = '0;
        pop_ok[0] = pop[0] & ~almost_empty[0];
        for (int unsigned i = 1; i < N_POP; i++)
            pop_ok[i] = pop_ok[i-1] & pop[i] & ~almost_empty[i];
        pop_cnt = '0;
        for (int unsigned i = 0; i < N_POP; i++)
            pop_cnt = pop_cnt + CW'(pop_ok[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + AW'(push_cnt);
            rptr <= rptr + AW'(pop_cnt);
            cnt  <= cnt + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N_PUSH; j++)
            if (push_ok[j] && !flush)
                mem[wptr + AW'(j)] <= din[j];
    end

    always_comb begin
        for (int unsigned i = 0; i < N_POP; i++)
            dout[i] = mem[rptr + AW'(i)];
    end

    rvv_backend_sva #(
        .N_PUSH (N_PUSH),
        .N_POP  (N_POP),
        .DEPTH  (DEPTH),
        .CW     (CW)
    ) u_sva (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .cnt      (cnt),
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt)
    );

endmodule

// File: rtl/rvv_backend_sva.sv
// Shared assertion checker for multi-port FIFOs: contiguous request
// vectors and no count overflow/underflow.
module rvv_backend_sva #(
    parameter int unsigned N_PUSH = 2,
    parameter int unsigned N_POP  = 2,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CW     = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              rst_n,
    input logic [N_PUSH-1:0] push,
    input logic [N_POP-1:0]  pop,
    input logic [CW-1:0]     cnt,
    input logic [CW-1:0]     push_cnt,
    input logic [CW-1:0]     pop_cnt
);

    a_push_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (push & (push + N_PUSH'(1))) == '0)
        else $error("non-contiguous push vector %b", push);

    a_pop_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (pop & (pop + N_POP'(1))) == '0)
        else $error("non-contiguous pop vector %b", pop);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        pop_cnt <= cnt)
        else $error("fifo underflow");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ((CW+1)'(cnt) + (CW+1)'(push_cnt) - (CW+1)'(pop_cnt)) <= (CW+1)'(DEPTH))
        else $error("fifo overflow");

endmodule

// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: multi_fifo specialised for ALU_RS_t with
// dispatch-side and execute-side port naming.
`ifndef NUM_ALU
`define NUM_ALU 2
`endif
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif
`ifndef ALU_RS_DEPTH
`define ALU_RS_DEPTH 8
`endif

module rvv_backend_alu_rs
    import rvv_backend_pkg::*;
#(
    parameter int unsigned DEPTH    = `ALU_RS_DEPTH,
    parameter int unsigned NUM_PUSH = `NUM_DP_UOP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PUSH-1:0]      push_dp2rs,
    input  ALU_RS_t [NUM_PUSH-1:0]   uop_dp2rs,
    output logic                     fifo_full_rs2dp,
    output logic [NUM_PUSH-1:0]      fifo_almost_full_rs2dp,
    input  logic [`NUM_ALU-1:0]      pop_ex2rs,
    output ALU_RS_t [`NUM_ALU-1:0]   alu_uop_rs2ex,
    output logic                     fifo_empty_rs2ex,
    output logic [`NUM_ALU-1:0]      fifo_almost_empty_rs2ex,
    input  logic                     trap_flush_rvv
);

    multi_fifo #(
        .WIDTH  ($bits(ALU_RS_t)),
        .DEPTH  (DEPTH),
        .N_PUSH (NUM_PUSH),
        .N_POP  (`NUM_ALU)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (trap_flush_rvv),
        .push         (push_dp2rs),
        .din          (uop_dp2rs),
        .full         (fifo_full_rs2dp),
        .almost_full  (fifo_almost_full_rs2dp),
        .pop          (pop_ex2rs),
        .dout         (alu_uop_rs2ex),
        .empty        (fifo_empty_rs2ex),
        .almost_empty (fifo_almost_empty_rs2ex)
    );

endmodule

// File: tb/tb_rvv_backend_alu_rs.sv
// Scoreboard bench for rvv_backend_alu_rs (DEPTH=8, 2 push, 2 pop ports):
// directed steps push expected uops into a queue, a monitor checks pops.
module tb_rvv_backend_alu_rs;
    import rvv_backend_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    push_dp2rs;
    ALU_RS_t [1:0] uop_dp2rs;
    logic          fifo_full_rs2dp;
    logic [1:0]    fifo_almost_full_rs2dp;
    logic [1:0]    pop_ex2rs;
    ALU_RS_t [1:0] alu_uop_rs2ex;
    logic          fifo_empty_rs2ex;
    logic [1:0]    fifo_almost_empty_rs2ex;
    logic          trap_flush_rvv;

    int      checks = 0;
    int      errors = 0;
    ALU_RS_t exp_q[$];

    always #5 clk = ~clk;

    rvv_backend_alu_rs #(
        .DEPTH    (8),
        .NUM_PUSH (2)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .push_dp2rs              (push_dp2rs),
        .uop_dp2rs               (uop_dp2rs),
        .fifo_full_rs2dp         (fifo_full_rs2dp),
        .fifo_almost_full_rs2dp  (fifo_almost_full_rs2dp),
        .pop_ex2rs               (pop_ex2rs),
        .alu_uop_rs2ex           (alu_uop_rs2ex),
        .fifo_empty_rs2ex        (fifo_empty_rs2ex),
        .fifo_almost_empty_rs2ex (fifo_almost_empty_rs2ex),
        .trap_flush_rvv          (trap_flush_rvv)
    );

    function automatic ALU_RS_t make_uop(input int unsigned k);
        ALU_RS_t u;
        u.alu_op   = 4'(k);
        u.vd_index = 5'(k * 3);
        u.rs1_data = 32'hC0DE_0000 + k;
        return u;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected flags derived from a hand-computed entry count (DEPTH=8).
    task automatic check_flags(input string name, input int unsigned cnt);
        chk({name, " empty"}, 64'(fifo_empty_rs2ex), 64'(cnt == 0));
        chk({name, " almost_empty"}, 64'(fifo_almost_empty_rs2ex), 64'({cnt <= 1, cnt == 0}));
        chk({name, " full"}, 64'(fifo_full_rs2dp), 64'(cnt == 8));
        chk({name, " almost_full"}, 64'(fifo_almost_full_rs2dp), 64'({cnt >= 7, cnt >= 8}));
    endtask

    // Entered and left at posedge+1: drive, cross one edge, record accepted uops.
    task automatic step(input logic [1:0] push, input int unsigned k0, input int unsigned k1,
                        input logic [1:0] pop, input logic flush, input int unsigned n_acc,
                        input int unsigned exp_cnt, input string name);
        ALU_RS_t u0;
        ALU_RS_t u1;
        u0 = make_uop(k0);
        u1 = make_uop(k1);
        push_dp2rs     = push;
        uop_dp2rs[0]   = u0;
        uop_dp2rs[1]   = u1;
        pop_ex2rs      = pop;
        trap_flush_rvv = flush;
        @(posedge clk);
        #1;
        push_dp2rs     = 2'b00;
        pop_ex2rs      = 2'b00;
        trap_flush_rvv = 1'b0;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (n_acc >= 1) exp_q.push_back(u0);
            if (n_acc >= 2) exp_q.push_back(u1);
        end
        check_flags(name, exp_cnt);
    endtask

    // Monitor: on each requested pop, the presented slot must match the queue head.
    initial begin
        ALU_RS_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && trap_flush_rvv === 1'b0) begin
                for (int i = 0; i < 2; i++) begin
                    if (pop_ex2rs[i] && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("slot%0d", i), 64'(alu_uop_rs2ex[i]), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        push_dp2rs     = 2'b00;
        pop_ex2rs      = 2'b00;
        trap_flush_rvv = 1'b0;
        uop_dp2rs      = '0;
        #2;
        check_flags("reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_flags("release", 0);

        step(2'b11, 1, 2, 2'b00, 1'b0, 2, 2, "push2");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 0, "pop2");

        step(2'b11, 3, 4, 2'b00, 1'b0, 2, 2, "fill_a");
        step(2'b11, 5, 6, 2'b00, 1'b0, 2, 4, "fill_b");
        step(2'b11, 7, 8, 2'b00, 1'b0, 2, 6, "fill_c");
        step(2'b01, 9, 0, 2'b00, 1'b0, 1, 7, "fill7");
        step(2'b11, 10, 11, 2'b00, 1'b0, 1, 8, "push_at7");
        step(2'b11, 12, 13, 2'b00, 1'b0, 0, 8, "push_full");
        step(2'b11, 14, 15, 2'b11, 1'b0, 0, 6, "pushpop_full");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 4, "drain_a");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 2, "drain_b");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 0, "drain_c");

        step(2'b11, 16, 17, 2'b11, 1'b0, 2, 2, "pushpop_empty");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 0, "drain_d");

        step(2'b01, 18, 0, 2'b00, 1'b0, 1, 1, "hold1");
        step(2'b11, 19, 20, 2'b11, 1'b0, 2, 2, "pop1push2");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 0, "drain_e");

        // Fifteen entries pushed so far; seven more moves both pointers to 6.
        step(2'b11, 21, 22, 2'b00, 1'b0, 2, 2, "adv_a");
        step(2'b11, 23, 24, 2'b00, 1'b0, 2, 4, "adv_b");
        step(2'b11, 25, 26, 2'b00, 1'b0, 2, 6, "adv_c");
        step(2'b01, 27, 0, 2'b00, 1'b0, 1, 7, "adv_d");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 5, "adv_e");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 3, "adv_f");
        step(2'b00, 0, 0, 2'b11, 1'b0, 0, 1, "adv_g");
        step(2'b00, 0, 0, 2'b01, 1'b0, 0, 0, "adv_h");

        step(2'b11, 28, 29, 2'b00, 1'b0, 2, 2, "wrap_load_a");
        step(2'b11, 30, 31, 2'b00, 1'b0, 2, 4, "wrap_load_b");
        for (int k = 0; k < 8; k++)
            step(2'b11, 32 + 2 * k, 33 + 2 * k, 2'b11, 1'b0, 2, 4, $sformatf("wrap%0d", k));

        step(2'b01, 48, 0, 2'b00, 1'b0, 1, 5, "hold5");
        step(2'b11, 49, 50, 2'b11, 1'b1, 0, 0, "flush");
        step(2'b01, 51, 0, 2'b00, 1'b0, 1, 1, "post_flush_push");
        step(2'b00, 0, 0, 2'b01, 1'b0, 0, 0, "post_flush_pop");

        step(2'b11, 52, 53, 2'b00, 1'b0, 2, 2, "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        check_flags("rst_mid", 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_flags("rst_rel", 0);
        step(2'b01, 54, 0, 2'b00, 1'b0, 1, 1, "post_rst_push");
        step(2'b00, 0, 0, 2'b01, 1'b0, 0, 0, "post_rst_pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvv_backend_alu_rs.md
RVV_BACKEND_ALU_RS -- requirements
Module: rvv_backend_alu_rs

Interface
REQ-001 The block SHALL have parameter DEPTH, default `ALU_RS_DEPTH (8): number of entries, a power of two, at least NUM_PUSH and at least `NUM_ALU.
REQ-002 The block SHALL have parameter NUM_PUSH, default `NUM_DP_UOP (2): number of push ports from dispatch.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port push_dp2rs, input, [NUM_PUSH-1:0]: push requests; the set bits are contiguous from bit 0.
REQ-006 The block SHALL have port uop_dp2rs, input, ALU_RS_t [NUM_PUSH-1:0]: push payload; port j carries the j-th uop in program order.
REQ-007 The block SHALL have port fifo_full_rs2dp, output, 1 bit: high when 0 entries are free.
REQ-008 The block SHALL have port fifo_almost_full_rs2dp, output, [NUM_PUSH-1:0]: bit j is high when fewer than j+1 entries are free.
REQ-009 The block SHALL have port pop_ex2rs, input, [`NUM_ALU-1:0]: pop requests; the set bits are contiguous from bit 0.
REQ-010 The block SHALL have port alu_uop_rs2ex, output, ALU_RS_t [`NUM_ALU-1:0]: slot i presents the entry at read pointer + i (mod DEPTH).
REQ-011 The block SHALL have port fifo_empty_rs2ex, output, 1 bit: high when the entry count is 0.
REQ-012 The block SHALL have port fifo_almost_empty_rs2ex, output, [`NUM_ALU-1:0]: bit i is high when the entry count is at most i.
REQ-013 The block SHALL have port trap_flush_rvv, input, 1 bit: discards all entries.

Function
REQ-014 Accepted push count SHALL equal popcount(push_dp2rs & ~fifo_almost_full_rs2dp); entries are written in port order at the write pointer, with wrap mod DEPTH.
REQ-015 Accepted pop count SHALL equal popcount(pop_ex2rs & ~fifo_almost_empty_rs2ex); the read pointer advances by that count, with wrap mod DEPTH.
REQ-016 Full/empty flags SHALL be computed from the registered count only; free space from same-cycle pops SHALL NOT be credited to pushes.
REQ-017 Next count SHALL be count + accepted pushes - accepted pops; the count register SHALL be $clog2(DEPTH)+1 bits and SHALL never exceed DEPTH or go below 0.
REQ-018 A pushed entry SHALL first appear on alu_uop_rs2ex the cycle after it is accepted; there is no same-cycle bypass.
REQ-019 alu_uop_rs2ex[i] SHALL be combinational from storage and pointers; its value is don't-care while fifo_almost_empty_rs2ex[i]=1.
REQ-020 Simultaneous push and pop while full SHALL accept only the pops; while empty, only the pushes.
REQ-021 A non-contiguous push or pop vector SHALL fire an SVA error; the block SHALL honour only the contiguous low-order prefix.
REQ-022 Pointer wrap SHALL be seamless: a multi-entry push or pop straddling index DEPTH-1 to 0 SHALL preserve order.
REQ-023 trap_flush_rvv=1 SHALL, on the next edge, set both pointers and the count to 0; pushes and pops in that cycle SHALL be ignored.
REQ-024 Flush SHALL take priority over all same-cycle push and pop activity.

Reset
REQ-025 While rst_n=0, pointers and count SHALL be 0, regardless of clk.
REQ-026 While rst_n=0, outputs SHALL be: fifo_empty_rs2ex=1, fifo_almost_empty_rs2ex all 1, fifo_full_rs2dp=0, fifo_almost_full_rs2dp all 0.
REQ-027 Storage SHALL NOT require reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-029 The first push after reset release SHALL land at index 0.

Structure
REQ-030 ALU_RS_t, `NUM_ALU, `NUM_DP_UOP and `ALU_RS_DEPTH SHALL live in the shared rvv_backend package/header.
REQ-031 Assertions SHALL live in the shared SVA include: no overflow, no underflow, contiguous push/pop vectors.
REQ-032 Storage and pointers SHALL be one generic sub-module, multi_fifo, parameterised by width, depth, push ports and pop ports; rvv_backend_alu_rs wraps it for ALU_RS_t and the port naming.

Verification
REQ-033 After reset, push uops A,B on both ports in one cycle: next cycle fifo_empty_rs2ex=0, fifo_almost_empty_rs2ex=2'b00, slot0=A, slot1=B.
REQ-034 With DEPTH=8 holding 7 entries, push_dp2rs=2'b11: only port 0 is accepted, count becomes 8, fifo_full_rs2dp=1, fifo_almost_full_rs2dp=2'b11.
REQ-035 With 1 entry held, pop_ex2rs=2'b11: one entry is removed and count becomes 0; in the same cycle push 2 entries: next count is 2, data in order.
REQ-036 Wrap: set read pointer=6 and 4 entries held (indices 6,7,0,1), then pop 2 and push 2 each cycle for 8 cycles: order is preserved and count stays at 4.
REQ-037 With 5 entries held, assert trap_flush_rvv together with a push of 2 and a pop of 2: next cycle count=0, empty=1, and no pushed entry appears.
REQ-038 Assert rst_n low mid-stream between clock edges: flags reach their reset values immediately, and after release a new push appears on slot 0.
